// File: rtl/decode_queue.sv
// Decode-on-entry instruction queue: decodes 32-bit words as they are pushed and
// presents the oldest decoded entry to register read over a valid/ready handshake.
module decode_queue #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [31:0]                in_instr,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [5:0]                 out_opcode,
    output logic [4:0]                 out_rd,
    output logic [4:0]                 out_rs,
    output logic [4:0]                 out_rt,
    output logic [4:0]                 out_shift,
    output logic [5:0]                 out_funct,
    output logic [DATA_W-1:0]          out_imm,
    output logic [25:0]                out_jump,
    output logic [1:0]                 out_itype,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    localparam logic [1:0] ITYPE_R = 2'd0;
    localparam logic [1:0] ITYPE_I = 2'd1;
    localparam logic [1:0] ITYPE_J = 2'd2;

    typedef struct packed {
        logic [5:0]        opcode;
        logic [4:0]        rd;
        logic [4:0]        rs;
        logic [4:0]        rt;
        logic [4:0]        shift;
        logic [5:0]        funct;
        logic [DATA_W-1:0] imm;
        logic [25:0]       jump;
        logic [1:0]        itype;
    } entry_t;

    // Logical-immediate opcodes (andi/ori/xori) zero-extend; everything else sign-extends.
    function automatic logic [DATA_W-1:0] ext_imm(input logic [5:0] op, input logic [15:0] raw);
        logic signed [15:0] raw_s;
        raw_s = signed'(raw);
        if (op == 6'h0C || op == 6'h0D || op == 6'h0E)
            return DATA_W'(raw);
        else
            return DATA_W'(raw_s);
    endfunction

    function automatic logic [1:0] classify(input logic [5:0] op);
        if (op == 6'h00)
            return ITYPE_R;
        else if (op == 6'h02 || op == 6'h03)
            return ITYPE_J;
        else
            return ITYPE_I;
    endfunction

    entry_t          mem [DEPTH];
    entry_t          dec_p0;
    entry_t          head;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic            push;
    logic            pop;

    // Decode on the write side so the head entry is ready the cycle after its push.
    always_comb begin
        dec_p0        = '0;
        dec_p0.opcode = in_instr[31:26];
        dec_p0.rd     = in_instr[25:21];
        dec_p0.rs     = in_instr[20:16];
        dec_p0.rt     = in_instr[15:11];
        dec_p0.shift  = in_instr[10:6];
        dec_p0.funct  = in_instr[5:0];
        dec_p0.imm    = ext_imm(in_instr[31:26], in_instr[15:0]);
        dec_p0.jump   = in_instr[25:0];
        dec_p0.itype  = classify(in_instr[31:26]);
    end

    assign in_ready  = (count < FULL);
    assign out_valid = (count != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage carries no reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= dec_p0;
    end

    assign head       = mem[rd_ptr];
    assign out_opcode = head.opcode;
    assign out_rd     = head.rd;
    assign out_rs     = head.rs;
    assign out_rt     = head.rt;
    assign out_shift  = head.shift;
    assign out_funct  = head.funct;
    assign out_imm    = head.imm;
    assign out_jump   = head.jump;
    assign out_itype  = head.itype;

endmodule

// File: tb/tb_decode_queue.sv
// Scoreboard bench for decode_queue: a monitor tracks occupancy and compares every
// popped entry against the expected decode of the accepted word, in FIFO order.
module tb_decode_queue;

    localparam int DEPTH  = 4;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst_n, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0]       in_instr;
    logic [5:0]        out_opcode, out_funct;
    logic [4:0]        out_rd, out_rs, out_rt, out_shift;
    logic [DATA_W-1:0] out_imm;
    logic [25:0]       out_jump;
    logic [1:0]        out_itype;
    logic [2:0]        count;

    typedef struct {
        logic [31:0] word;
        logic [5:0]  opcode;
        logic [4:0]  rd, rs, rt, shift;
        logic [5:0]  funct;
        logic [31:0] imm;
        logic [25:0] jump;
        logic [1:0]  itype;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   m_cnt  = 0;
    bit   mon_en = 0;

    decode_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_opcode(out_opcode), .out_rd(out_rd), .out_rs(out_rs), .out_rt(out_rt),
        .out_shift(out_shift), .out_funct(out_funct), .out_imm(out_imm),
        .out_jump(out_jump), .out_itype(out_itype), .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference decode written from the field table with shifts and masks.
    function automatic exp_t model(input logic [31:0] w);
        exp_t e;
        logic [5:0] op;
        op       = 6'((w >> 26) & 32'h3F);
        e.word   = w;
        e.opcode = op;
        e.rd     = 5'((w >> 21) & 32'h1F);
        e.rs     = 5'((w >> 16) & 32'h1F);
        e.rt     = 5'((w >> 11) & 32'h1F);
        e.shift  = 5'((w >> 6) & 32'h1F);
        e.funct  = 6'(w & 32'h3F);
        e.jump   = 26'(w & 32'h03FF_FFFF);
        e.itype  = (op == 0) ? 2'd0 : (op == 2 || op == 3) ? 2'd2 : 2'd1;
        if (op == 6'h0C || op == 6'h0D || op == 6'h0E)
            e.imm = w & 32'h0000_FFFF;
        else
            e.imm = (w & 32'h0000_8000) ? (w | 32'hFFFF_0000) : (w & 32'h0000_FFFF);
        return e;
    endfunction

    // Monitor: occupancy model plus in-order comparison of every popped entry.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("count", 32'(count), 32'(m_cnt));
            chk("out_valid", 32'(out_valid), 32'(m_cnt != 0));
            chk("in_ready", 32'(in_ready), 32'(m_cnt < DEPTH));
            if (!rst_n || flush) begin
                sb.delete();
                m_cnt = 0;
            end else begin
                bit do_push, do_pop;
                do_push = in_valid && (m_cnt < DEPTH);
                do_pop  = out_ready && (m_cnt != 0);
                if (do_pop) begin
                    if (sb.size() == 0) begin
                        chk("sb_underflow", 32'd1, 32'd0);
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        chk("pop_opcode", 32'(out_opcode), 32'(e.opcode));
                        chk("pop_rd", 32'(out_rd), 32'(e.rd));
                        chk("pop_rs", 32'(out_rs), 32'(e.rs));
                        chk("pop_rt", 32'(out_rt), 32'(e.rt));
                        chk("pop_shift", 32'(out_shift), 32'(e.shift));
                        chk("pop_funct", 32'(out_funct), 32'(e.funct));
                        chk("pop_imm", out_imm, e.imm);
                        chk("pop_jump", 32'(out_jump), 32'(e.jump));
                        chk("pop_itype", 32'(out_itype), 32'(e.itype));
                    end
                end
                if (do_push)
                    sb.push_back(model(in_instr));
                m_cnt = m_cnt + int'(do_push) - int'(do_pop);
            end
        end
    end

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_instr = '0;
        cyc();
        mon_en = 1;
        cyc();
        rst_n = 1'b1;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);

        // R-type word
        in_valid = 1'b1; in_instr = 32'h0123_4820;
        cyc();
        in_valid = 1'b0;
        chk("r_valid", 32'(out_valid), 32'd1);
        chk("r_itype", 32'(out_itype), 32'd0);
        chk("r_opcode", 32'(out_opcode), 32'd0);
        chk("r_rd", 32'(out_rd), 32'd9);
        chk("r_rs", 32'(out_rs), 32'd3);
        chk("r_rt", 32'(out_rt), 32'd9);
        chk("r_shift", 32'(out_shift), 32'd0);
        chk("r_funct", 32'(out_funct), 32'h20);
        chk("r_count", 32'(count), 32'd1);
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;

        // Sign- and zero-extended immediates
        in_valid = 1'b1; in_instr = 32'h2108_FFFC;
        cyc();
        in_instr = 32'h3508_8000;
        cyc();
        in_valid = 1'b0;
        chk("i1_itype", 32'(out_itype), 32'd1);
        chk("i1_imm", out_imm, 32'hFFFF_FFFC);
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
        chk("i2_itype", 32'(out_itype), 32'd1);
        chk("i2_imm", out_imm, 32'h0000_8000);
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;

        // J-type
        in_valid = 1'b1; in_instr = 32'h0C00_0040;
        cyc();
        in_valid = 1'b0;
        chk("j_itype", 32'(out_itype), 32'd2);
        chk("j_jump", 32'(out_jump), 32'h40);
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;

        // Fill past capacity; words 5 and 6 must be refused
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            in_instr = 32'h2000_0000 + 32'((i + 1) * 32'h0001_1111);
            cyc();
        end
        in_valid = 1'b0;
        chk("full_count", 32'(count), 32'd4);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        cyc(5);
        out_ready = 1'b0;
        chk("drain_count", 32'(count), 32'd0);

        // Continuous stream across pointer wrap
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1;
            in_instr = {6'(i * 5), 10'(i), 16'(16'h7FF0 + i * 16'h0401)};
            cyc();
        end
        in_valid = 1'b0;
        cyc(2);
        out_ready = 1'b0;

        // Flush with simultaneous push and pop
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_instr = 32'hA000_1000 + 32'(i);
            cyc();
        end
        flush = 1'b1; in_valid = 1'b1; out_ready = 1'b1; in_instr = 32'h1234_5678;
        cyc();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        chk("flush_count", 32'(count), 32'd0);
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        chk("flush_in_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b1; in_instr = 32'hFFFF_FFFF;
        cyc();
        in_valid = 1'b0;
        chk("post_flush_opcode", 32'(out_opcode), 32'h3F);
        chk("post_flush_itype", 32'(out_itype), 32'd1);
        chk("post_flush_imm", out_imm, 32'hFFFF_FFFF);
        out_ready = 1'b1;
        cyc(2);
        out_ready = 1'b0;
        chk("end_sb_empty", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
